// File: rtl/array_sequencer.sv
// Job sequencer for an NxN systolic array: weight load, skewed ifmap streaming, drain.
// Partial-sum rows are flagged valid 2N-1 cycles after their lane-0 data enters the array.
module array_sequencer #(
    parameter int N      = 16,
    parameter int DW     = 8,
    parameter int ROW_AW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [ROW_AW:0]      num_rows_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 wgt_rd_en_o,
    output logic [$clog2(N)-1:0] wgt_rd_addr_o,
    input  logic [N*DW-1:0]      wgt_rd_data_i,
    output logic                 inp_rd_en_o,
    output logic [ROW_AW-1:0]    inp_rd_addr_o,
    input  logic [N*DW-1:0]      inp_rd_data_i,
    output logic                 arr_en_o,
    output logic                 arr_load_weight_o,
    output logic [N*DW-1:0]      arr_weight_row_o,
    output logic [N*DW-1:0]      arr_ifmap_o,
    output logic                 out_valid_o,
    output logic [ROW_AW-1:0]    out_row_idx_o
);

    localparam int WAW = $clog2(N);
    localparam int CW  = (ROW_AW + 1 > $clog2(2 * N)) ? ROW_AW + 1 : $clog2(2 * N);
    localparam int EW  = CW + 1;

    localparam logic [CW-1:0] CNT_W_LAST = CW'(N);
    localparam logic [CW-1:0] CNT_D_LAST = CW'(2 * N - 2);
    localparam logic [EW-1:0] EL_FIRST   = EW'(2 * N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ROW_AW:0]   rows_q, rows_d;
    logic [EW-1:0]     el_q, el_d;
    logic              vld_q, vld_d;
    logic              flush;
    logic              in_flow;
    logic [N*DW-1:0]   lane_in;

    assign flush = abort_i && (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD_W;
                    rows_d  = num_rows_i;
                end
            end
            S_LOAD_W: begin
                if (cnt_q == CNT_W_LAST) state_d = (rows_q != '0) ? S_STREAM : S_DONE;
            end
            // The extra cycle at cnt==rows lets the last returned row enter the skew unit.
            S_STREAM: begin
                if (cnt_q == CW'(rows_q)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == CNT_D_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;

        cnt_d = (state_d != state_q || state_d == S_IDLE) ? '0 : cnt_q + CW'(1);

        el_d = '0;
        if (state_d == S_STREAM || state_d == S_DRAIN) begin
            el_d = (state_q == S_STREAM || state_q == S_DRAIN) ? el_q + EW'(1) : '0;
        end
    end

    always_comb begin
        wgt_rd_en_o       = 1'b0;
        wgt_rd_addr_o     = '0;
        inp_rd_en_o       = 1'b0;
        inp_rd_addr_o     = '0;
        arr_en_o          = 1'b0;
        arr_load_weight_o = 1'b0;
        unique case (state_q)
            S_LOAD_W: begin
                if (cnt_q < CNT_W_LAST) begin
                    wgt_rd_en_o   = 1'b1;
                    wgt_rd_addr_o = cnt_q[WAW-1:0];
                end
                if (cnt_q != '0) begin
                    arr_load_weight_o = 1'b1;
                    arr_en_o          = 1'b1;
                end
            end
            S_STREAM: begin
                if (cnt_q < CW'(rows_q)) begin
                    inp_rd_en_o   = 1'b1;
                    inp_rd_addr_o = cnt_q[ROW_AW-1:0];
                end
                arr_en_o = (cnt_q != '0);
            end
            S_DRAIN:  arr_en_o = 1'b1;
            default: ;
        endcase
    end

    assign vld_d = flush ? 1'b0 : inp_rd_en_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rows_q  <= '0;
            el_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
            el_q    <= el_d;
            vld_q   <= vld_d;
        end
    end

    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE);
    assign arr_weight_row_o = arr_load_weight_o ? wgt_rd_data_i : '0;

    // el_q counts cycles since STREAM entry; row r's psum emerges at el = r + 2N.
    assign in_flow       = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign out_valid_o   = in_flow && (el_q >= EL_FIRST) && (el_q < EW'(rows_q) + EL_FIRST);
    assign out_row_idx_o = out_valid_o ? ROW_AW'(el_q - EL_FIRST) : '0;

    // Returned buffer data is only meaningful the cycle after a read; zero otherwise.
    assign lane_in            = vld_q ? inp_rd_data_i : '0;
    assign arr_ifmap_o[DW-1:0] = lane_in[DW-1:0];

    for (genvar i = 1; i < N; i++) begin : g_skew
        logic [DW-1:0] sr_q [i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < i; j++) sr_q[j] <= '0;
            end else if (flush) begin
                for (int j = 0; j < i; j++) sr_q[j] <= '0;
            end else begin
                sr_q[0] <= lane_in[i*DW +: DW];
                for (int j = 1; j < i; j++) sr_q[j] <= sr_q[j-1];
            end
        end

        assign arr_ifmap_o[i*DW +: DW] = sr_q[i-1];
    end

endmodule

// File: tb/tb_array_sequencer.sv
// Directed bench for array_sequencer: per-cycle expected timeline derived from the job schedule.
module tb_array_sequencer;

    localparam int N      = 16;
    localparam int DW     = 8;
    localparam int ROW_AW = 8;
    localparam int W      = N * DW;

    logic                 clk;
    logic                 rst_n;
    logic                 start_i;
    logic                 abort_i;
    logic [ROW_AW:0]      num_rows_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 wgt_rd_en_o;
    logic [$clog2(N)-1:0] wgt_rd_addr_o;
    logic [W-1:0]         wgt_rd_data_i;
    logic                 inp_rd_en_o;
    logic [ROW_AW-1:0]    inp_rd_addr_o;
    logic [W-1:0]         inp_rd_data_i;
    logic                 arr_en_o;
    logic                 arr_load_weight_o;
    logic [W-1:0]         arr_weight_row_o;
    logic [W-1:0]         arr_ifmap_o;
    logic                 out_valid_o;
    logic [ROW_AW-1:0]    out_row_idx_o;

    int n_checks;
    int n_errors;

    array_sequencer #(.N(N), .DW(DW), .ROW_AW(ROW_AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .num_rows_i        (num_rows_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .wgt_rd_en_o       (wgt_rd_en_o),
        .wgt_rd_addr_o     (wgt_rd_addr_o),
        .wgt_rd_data_i     (wgt_rd_data_i),
        .inp_rd_en_o       (inp_rd_en_o),
        .inp_rd_addr_o     (inp_rd_addr_o),
        .inp_rd_data_i     (inp_rd_data_i),
        .arr_en_o          (arr_en_o),
        .arr_load_weight_o (arr_load_weight_o),
        .arr_weight_row_o  (arr_weight_row_o),
        .arr_ifmap_o       (arr_ifmap_o),
        .out_valid_o       (out_valid_o),
        .out_row_idx_o     (out_row_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] wrow(input int k);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(k * 16 + i);
        return v;
    endfunction

    function automatic logic [W-1:0] inrow(input int r);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(r * 16 + i);
        return v;
    endfunction

    // Buffer models: one-cycle read latency, junk on cycles without a read.
    always @(posedge clk) begin
        wgt_rd_data_i <= wgt_rd_en_o ? wrow(int'(wgt_rd_addr_o)) : {N{8'hEE}};
        inp_rd_data_i <= inp_rd_en_o ? inrow(int'(inp_rd_addr_o)) : {N{8'h5A}};
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     busy_o, 0);
        check({tag, "_done"},     done_o, 0);
        check({tag, "_wgt_en"},   wgt_rd_en_o, 0);
        check({tag, "_wgt_addr"}, wgt_rd_addr_o, 0);
        check({tag, "_inp_en"},   inp_rd_en_o, 0);
        check({tag, "_inp_addr"}, inp_rd_addr_o, 0);
        check({tag, "_arr_en"},   arr_en_o, 0);
        check({tag, "_load"},     arr_load_weight_o, 0);
        check({tag, "_wrow"},     arr_weight_row_o, 0);
        check({tag, "_ifmap"},    arr_ifmap_o, 0);
        check({tag, "_ovalid"},   out_valid_o, 0);
        check({tag, "_oidx"},     out_row_idx_o, 0);
    endtask

    // kill_kind: 0 none, 1 abort during cycle kill_c, 2 async reset during cycle kill_c.
    task automatic run_job(input int rows, input int kill_c, input int kill_kind,
                           input bit hold, input bit hold_next, input bit abort_c0);
        int s;
        int done_c;
        int r;
        bit ld;
        bit ie;
        bit ae;
        bit ov;
        logic [W-1:0] exp_if;
        s      = N + 2;
        done_c = (rows > 0) ? 3 * N + 2 + rows : N + 2;
        @(negedge clk);
        check("idle_busy", busy_o, 0);
        check("idle_done", done_o, 0);
        check("idle_arr_en", arr_en_o, 0);
        start_i    = 1'b1;
        abort_i    = abort_c0;
        num_rows_i = (ROW_AW + 1)'(rows);
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            ld = (c >= 2) && (c <= N + 1);
            ie = (rows > 0) && (c >= s) && (c < s + rows);
            ae = ld || ((rows > 0) && (c >= s + 1) && (c <= s + rows + 2 * N - 1));
            ov = (rows > 0) && (c >= s + 2 * N) && (c <= s + 2 * N - 1 + rows);
            exp_if = '0;
            for (int i = 0; i < N; i++) begin
                r = c - s - 1 - i;
                if (rows > 0 && r >= 0 && r < rows) exp_if[i*DW +: DW] = DW'(16 * r + i);
            end
            check("busy", busy_o, 1);
            check("done", done_o, c == done_c);
            check("wgt_en", wgt_rd_en_o, (c >= 1) && (c <= N));
            if (c <= N) check("wgt_addr", wgt_rd_addr_o, c - 1);
            check("load", arr_load_weight_o, ld);
            check("wrow", arr_weight_row_o, ld ? wrow(c - 2) : '0);
            check("inp_en", inp_rd_en_o, ie);
            if (ie) check("inp_addr", inp_rd_addr_o, c - s);
            check("arr_en", arr_en_o, ae);
            check("ifmap", arr_ifmap_o, exp_if);
            check("ovalid", out_valid_o, ov);
            if (ov) check("oidx", out_row_idx_o, c - s - 2 * N);
            start_i    = hold;
            abort_i    = 1'b0;
            num_rows_i = 9'd7;
            if (c == kill_c) begin
                start_i = 1'b0;
                if (kill_kind == 1) begin
                    abort_i = 1'b1;
                    @(negedge clk);
                    check_zero("abort");
                    abort_i = 1'b0;
                end else begin
                    #2 rst_n = 1'b0;
                    #1 check_zero("rst_async");
                    @(negedge clk);
                    check_zero("rst_hold");
                    rst_n = 1'b1;
                end
                return;
            end
            if (c == done_c) start_i = hold_next;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b1;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        num_rows_i = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        run_job(3,   -1, 0, 0, 0, 0);
        run_job(0,   -1, 0, 0, 0, 0);
        run_job(1,   -1, 0, 0, 0, 0);
        run_job(256, -1, 0, 0, 0, 0);
        run_job(20,  N + 2 + 5, 1, 0, 0, 0);
        run_job(3,   -1, 0, 0, 0, 0);
        run_job(5,   5, 1, 0, 0, 0);
        run_job(2,   -1, 0, 0, 0, 1);
        run_job(2,   -1, 0, 1, 1, 0);
        run_job(3,   -1, 0, 1, 0, 0);
        run_job(10,  N + 2 + 3, 2, 0, 0, 0);
        run_job(4,   -1, 0, 0, 0, 0);

        @(negedge clk);
        check_zero("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
